run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 141 ++++++++++++++
 tb/tb_run_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Test-run sequencer: preloads CPU operands, releases CPU reset,
// waits for done or timeout, reads results back and reports pass/fail.
module run_ctrl #(
    parameter  int DW       = 8,
    parameter  int AW       = 8,
    parameter  int NOPS     = 2,
    parameter  int NRES     = 1,
    parameter  int OP_BASE  = 3,
    parameter  int RES_BASE = 5,
    parameter  int RST_CYC  = 2,
    parameter  int TIMEOUT  = 2000,
    localparam int CW       = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NOPS*DW-1:0] ops_in,
    input  logic [NRES*DW-1:0] exp_in,
    output logic               cpu_reset,
    input  logic               cpu_done,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy,
    output logic               finished,
    output logic               pass,
    output logic               timed_out,
    output logic [NRES*DW-1:0] results,
    output logic [CW-1:0]      cycles
);

    localparam int NW = 16;

    typedef enum logic [2:0] {
        IDLE, LOAD, HOLD, RUN, READ, REPORT
    } state_t;

    state_t             state, state_n;
    logic [NW-1:0]      cnt, cnt_n;
    logic [NOPS*DW-1:0] ops_q;
    logic [NRES*DW-1:0] exp_q;
    logic [NRES*DW-1:0] res_n;
    logic [CW-1:0]      cyc_inc;
    logic               run_to;
    logic               read_last;

    // State register and per-state cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, memory port drive and result merge
    always_comb begin
        state_n   = state;
        mem_addr  = '0;
        mem_wdata = '0;
        res_n     = results;
        run_to    = 1'b0;
        read_last = 1'b0;
        cyc_inc   = (cycles == CW'(TIMEOUT)) ? cycles : cycles + CW'(1);
        case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                mem_addr  = AW'(OP_BASE) + AW'(cnt);
                mem_wdata = ops_q[cnt*DW +: DW];
                if (cnt == NW'(NOPS - 1)) state_n = HOLD;
            end
            HOLD: begin
                if (cnt == NW'(RST_CYC - 1)) state_n = RUN;
            end
            RUN: begin
                if (cpu_done) begin
                    state_n = READ;
                end else if (cyc_inc == CW'(TIMEOUT)) begin
                    run_to  = 1'b1;
                    state_n = REPORT;
                end
            end
            READ: begin
                mem_addr              = AW'(RES_BASE) + AW'(cnt);
                res_n[cnt*DW +: DW]   = mem_rdata;
                if (cnt == NW'(NRES - 1)) begin
                    read_last = 1'b1;
                    state_n   = REPORT;
                end
            end
            REPORT: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n == state) ? cnt + NW'(1) : '0;
    end

    // Run datapath: latched stimulus, cycle count, results and verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_q     <= '0;
            exp_q     <= '0;
            results   <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
            pass      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ops_q     <= ops_in;
                exp_q     <= exp_in;
                results   <= '0;
                cycles    <= '0;
                timed_out <= 1'b0;
                pass      <= 1'b0;
            end
            if (state == RUN) begin
                cycles <= cyc_inc;
                if (run_to) begin
                    timed_out <= 1'b1;
                    pass      <= 1'b0;
                end
            end
            if (state == READ) begin
                results <= res_n;
                if (read_last) pass <= (res_n == exp_q);
            end
        end
    end

    assign cpu_reset = (state != RUN) || reset;
    assign mem_we    = (state == LOAD) && !reset;
    assign busy      = (state != IDLE) && !reset;
    assign finished  = (state == REPORT) && !reset;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl with a small behavioural CPU/memory stub.
// Expected verdicts are computed from the stub's programmed behaviour.
module tb_run_ctrl;

    localparam int TO   = 20;
    localparam int NOPS = 2;
    localparam int NRES = 1;
    localparam int RST  = 2;

    logic        clk = 1'b0;
    logic        reset, start, cpu_done, cpu_reset;
    logic        mem_we, busy, finished, pass, timed_out;
    logic [15:0] ops_in;
    logic [7:0]  exp_in, mem_addr, mem_wdata, mem_rdata, results;
    logic [4:0]  cycles;

    always #5 clk = ~clk;

    run_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ops_in(ops_in), .exp_in(exp_in),
        .cpu_reset(cpu_reset), .cpu_done(cpu_done),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .finished(finished), .pass(pass),
        .timed_out(timed_out), .results(results), .cycles(cycles)
    );

    // CPU stub: done on RUN cycle stub_delay (0 = never), writes result to 5
    logic [7:0] mem [256];
    int         stub_delay = 0;
    logic [7:0] stub_res   = 8'd0;
    int         run_cyc    = 0;
    int         tick       = 0;

    assign mem_rdata = mem[mem_addr];
    assign cpu_done  = !cpu_reset && stub_delay != 0 &&
                       (run_cyc + 1 == stub_delay);

    always @(posedge clk) begin
        tick    <= tick + 1;
        run_cyc <= cpu_reset ? 0 : run_cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (!cpu_reset) mem[5] <= stub_res;
    end

    typedef struct {
        logic [7:0] res;
        logic       ps;
        logic       to;
        int         cyc;
        int         lat;
        int         low;
        int         rd;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [15:0] wr_q [$];
    int          n_cmp = 0, n_bad = 0;
    int          fin_cnt = 0, n_low = 0, n_rd = 0, t0 = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Observe memory traffic and pop/compare on each finished pulse
    always @(negedge clk) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
        if (!cpu_reset) n_low++;
        if (busy && !mem_we && mem_addr == 8'd5) n_rd++;
        if (finished) begin
            fin_cnt++;
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check("results", results, e.res);
                check("pass", pass, e.ps);
                check("timed_out", timed_out, e.to);
                check("cycles", cycles, e.cyc);
                check("latency", tick - t0, e.lat);
                check("run_low", n_low, e.low);
                check("read_cnt", n_rd, e.rd);
            end
        end
    end

    task automatic run(input logic [7:0] o0, input logic [7:0] o1,
                       input logic [7:0] ex, input int dly,
                       input logic [7:0] rv, input bit rep);
        exp_t x;
        int   f0;
        bit   seen;
        stub_delay = dly;
        stub_res   = rv;
        if (dly != 0 && dly <= TO) begin
            x.res = rv; x.ps = (rv == ex); x.to = 1'b0; x.cyc = dly;
            x.lat = 1 + NOPS + RST + dly + NRES; x.low = dly; x.rd = NRES;
        end else begin
            x.res = 8'd0; x.ps = 1'b0; x.to = 1'b1; x.cyc = TO;
            x.lat = 1 + NOPS + RST + TO; x.low = TO; x.rd = 0;
        end
        ops_in = {o1, o0};
        exp_in = ex;
        start  = 1'b1;
        t0     = tick;
        n_low  = 0;
        n_rd   = 0;
        wr_q.delete();
        sb.push_back(x);
        f0   = fin_cnt;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            start = rep && (k == 6);
            if (fin_cnt != f0) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            check("finish_wait", 0, 1);
            sb.delete();
        end
        check("n_writes", wr_q.size(), NOPS);
        if (wr_q.size() >= 2) begin
            check("wr0", wr_q[0], {8'd3, o0});
            check("wr1", wr_q[1], {8'd4, o1});
        end
        repeat (3) @(negedge clk);
        check("one_finish", fin_cnt - f0, 1);
        check("idle_after", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        reset  = 1'b1;
        start  = 1'b1;
        ops_in = 16'h0000;
        exp_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_finished", finished, 0);
        check("rst_pass", pass, 0);
        check("rst_cycles", cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        run(8'd4, 8'd6, 8'd10, 5, 8'd10, 1'b0);
        run(8'd4, 8'd6, 8'd11, 5, 8'd10, 1'b0);
        run(8'd1, 8'd2, 8'd3, 0, 8'd9, 1'b0);
        run(8'd7, 8'd8, 8'd10, 20, 8'd10, 1'b0);

        repeat (5) @(negedge clk);
        check("hold_pass", pass, 1);
        check("hold_results", results, 8'd10);
        check("hold_cycles", cycles, 20);

        // Abort a hung run with reset in its third RUN cycle
        stub_delay = 0;
        ops_in     = 16'h0302;
        exp_in     = 8'h05;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && cpu_reset; k++) @(negedge clk);
        check("run_entered", cpu_reset, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("mid_cpu_reset", cpu_reset, 1);
        check("mid_busy", busy, 0);
        check("mid_mem_we", mem_we, 0);
        check("mid_finished", finished, 0);
        check("mid_timed_out", timed_out, 0);
        check("mid_pass", pass, 0);
        check("mid_results", results, 0);
        check("mid_cycles", cycles, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("start_in_reset", busy, 0);
        @(negedge clk);

        run(8'd4, 8'd6, 8'd10, 5, 8'd10, 1'b0);
        run(8'd9, 8'd9, 8'd33, 8, 8'd33, 1'b1);

        for (int r = 0; r < 4; r++) begin
            logic [7:0] a, b, v;
            int         d;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            d = $urandom_range(0, 22);
            run(a, b, ($urandom_range(0, 1) != 0) ? v : v + 8'd1, d, v,
                1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
